// File: rtl/rat_regfile.sv
// rat_regfile: register file with an integrated register alias table for the Tomasulo issue/CDB path.
// Define RAT_CDB_BYPASS_EN to forward a matching CDB broadcast to the read ports in the same cycle.
module rat_regfile #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    parameter int  TAG_W = 8,
    parameter int  NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD*TAG_W-1:0] rd_tag,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    input  logic [TAG_W-1:0]     iss_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [XLEN-1:0]      cdb_data,
    input  logic                 flush,
    output logic [AW:0]          pend_cnt,
    input  logic [AW-1:0]        debug_addr,
    output logic [XLEN-1:0]      debug_data
);
    logic [NREGS-1:0][XLEN-1:0]  r_reg, w_reg_nxt;
    logic [NREGS-1:0][TAG_W-1:0] r_rat, w_rat_nxt;
    logic [AW:0]                 r_pend, w_pend_nxt;
    logic                        w_cdb_hit, w_iss_ok;

    assign w_cdb_hit = cdb_valid && (cdb_tag != '0);
    assign w_iss_ok  = iss_en && (iss_rd != '0) && (iss_tag != '0) && !flush;

    // CDB first, then issue, then flush: later writes win on the alias only,
    // so the CDB data write always lands even when its tag clear is overridden.
    always_comb begin
        w_reg_nxt = r_reg;
        w_rat_nxt = r_rat;
        for (int r = 1; r < NREGS; r++) begin
            if (w_cdb_hit && (r_rat[r] == cdb_tag)) begin
                w_reg_nxt[r] = cdb_data;
                w_rat_nxt[r] = '0;
            end
        end
        if (w_iss_ok) w_rat_nxt[iss_rd] = iss_tag;
        if (flush)    w_rat_nxt = '0;
        w_reg_nxt[0] = '0;
        w_rat_nxt[0] = '0;
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (w_rat_nxt[r] != '0) w_pend_nxt = w_pend_nxt + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg  <= '0;
            r_rat  <= '0;
            r_pend <= '0;
        end else begin
            r_reg  <= w_reg_nxt;
            r_rat  <= w_rat_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign pend_cnt   = r_pend;
    assign debug_data = (debug_addr == '0) ? '0 : r_reg[debug_addr];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_byp;
        assign w_addr = rd_addr[k*AW +: AW];
`ifdef RAT_CDB_BYPASS_EN
        assign w_byp = w_cdb_hit && (w_addr != '0) && (r_rat[w_addr] == cdb_tag);
`else
        assign w_byp = 1'b0;
`endif
        assign rd_tag[k*TAG_W +: TAG_W] = w_byp ? '0 : r_rat[w_addr];
        assign rd_data[k*XLEN +: XLEN]  = w_byp ? cdb_data :
                                          (w_addr == '0) ? '0 : r_reg[w_addr];
    end
endmodule

// File: tb/tb_rat_regfile.sv
// Scoreboard bench for rat_regfile: driver queues expected outputs, negedge monitor pops and compares.
// Expectations follow RAT_CDB_BYPASS_EN when the bench is compiled with it defined.
module tb_rat_regfile;
    localparam int AW = 5;
`ifdef RAT_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [15:0] rd_tag;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [7:0]  iss_tag;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic [5:0]  pend_cnt;
    logic [4:0]  debug_addr;
    logic [31:0] debug_data;

    rat_regfile dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_tag(rd_tag),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .pend_cnt(pend_cnt), .debug_addr(debug_addr), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_id    = 0;

    localparam int D0 = 0, T0 = 1, D1 = 2, T1 = 3, PC = 4, DBG = 5;

    function automatic string kname(int k);
        case (k)
            D0:      return "rd_data0";
            T0:      return "rd_tag0";
            D1:      return "rd_data1";
            T1:      return "rd_tag1";
            PC:      return "pend_cnt";
            default: return "debug_data";
        endcase
    endfunction

    function automatic logic [31:0] got(int k);
        case (k)
            D0:      return rd_data[31:0];
            T0:      return {24'b0, rd_tag[7:0]};
            D1:      return rd_data[63:32];
            T1:      return {24'b0, rd_tag[15:8]};
            PC:      return {26'b0, pend_cnt};
            default: return debug_data;
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t c;
        logic [31:0] g;
        while (q.size() > 0) begin
            c = q.pop_front();
            g = got(c.kind);
            n_tests++;
            if (g !== c.exp) begin
                n_fail++;
                $display("FAIL chk%0d %s: got 0x%0h expected 0x%0h", c.id, kname(c.kind), g, c.exp);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v);
        chk_t c;
        c.id = n_id; c.kind = kind; c.exp = v;
        n_id++;
        q.push_back(c);
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic setrd(input int a0, input int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic issue(input int r, input logic [7:0] t);
        iss_en = 1'b1; iss_rd = 5'(r); iss_tag = t;
    endtask

    task automatic cdb(input logic [7:0] t, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic idle();
        iss_en = 1'b0; iss_rd = '0; iss_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; debug_addr = '0;
        idle();
        tk(); tk();
        rst = 1'b0;

        // reset state across every address on both ports
        for (int a = 0; a < 32; a++) begin
            setrd(a, 31 - a); debug_addr = 5'(a);
            expect_v(D0, 0); expect_v(T0, 0); expect_v(D1, 0);
            expect_v(T1, 0); expect_v(PC, 0); expect_v(DBG, 0);
            tk();
        end

        // issue r5 tag 0x23, broadcast 0x23
        setrd(5, 0); issue(5, 8'h23);
        expect_v(T0, 0); expect_v(PC, 0);
        tk();
        idle(); cdb(8'h23, 32'hDEADBEEF);
        expect_v(T0, BYP ? 32'h0 : 32'h23); expect_v(D0, BYP ? 32'hDEADBEEF : 32'h0); expect_v(PC, 1);
        tk();
        idle(); debug_addr = 5'd5;
        expect_v(D0, 32'hDEADBEEF); expect_v(T0, 0); expect_v(PC, 0); expect_v(DBG, 32'hDEADBEEF);
        tk();

        // two registers share tag 0x41, one broadcast clears both
        setrd(3, 7); issue(3, 8'h41);
        tk();
        issue(7, 8'h41);
        expect_v(T0, 32'h41); expect_v(T1, 0); expect_v(PC, 1);
        tk();
        idle(); cdb(8'h41, 32'h12);
        expect_v(T0, BYP ? 32'h0 : 32'h41); expect_v(T1, BYP ? 32'h0 : 32'h41);
        expect_v(D0, BYP ? 32'h12 : 32'h0); expect_v(D1, BYP ? 32'h12 : 32'h0); expect_v(PC, 2);
        tk();
        idle();
        expect_v(D0, 32'h12); expect_v(D1, 32'h12); expect_v(T0, 0); expect_v(T1, 0); expect_v(PC, 0);
        tk();

        // issue and CDB hit the same register in one cycle
        setrd(4, 0); issue(4, 8'h22);
        tk();
        issue(4, 8'h45); cdb(8'h22, 32'd7);
        expect_v(T0, BYP ? 32'h0 : 32'h22); expect_v(D0, BYP ? 32'd7 : 32'd0); expect_v(PC, 1);
        tk();
        idle();
        expect_v(D0, 32'd7); expect_v(T0, 32'h45); expect_v(PC, 1);
        tk();
        cdb(8'h45, 32'd9);
        tk();
        idle();
        expect_v(D0, 32'd9); expect_v(T0, 0); expect_v(PC, 0);
        tk();

        // flush with concurrent issue and a CDB write that must still land
        issue(1, 8'h31); tk();
        issue(2, 8'h32); tk();
        issue(3, 8'h34); tk();
        issue(9, 8'h33); tk();
        idle(); setrd(1, 9);
        expect_v(T0, 32'h31); expect_v(T1, 32'h33); expect_v(PC, 4);
        tk();
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd10; iss_tag = 8'h30; cdb(8'h33, 32'h99);
        setrd(3, 10);
        expect_v(T0, 32'h34); expect_v(T1, 0); expect_v(D0, 32'h12); expect_v(PC, 4);
        tk();
        idle();
        expect_v(T0, 0); expect_v(T1, 0); expect_v(D0, 32'h12); expect_v(D1, 0); expect_v(PC, 0);
        tk();
        setrd(9, 2);
        expect_v(D0, 32'h99); expect_v(T0, 0); expect_v(T1, 0); expect_v(D1, 0);
        tk();

        // same-cycle bypass (or not) on r6; debug port never bypasses
        setrd(0, 6); issue(6, 8'h2A);
        tk();
        idle(); cdb(8'h2A, 32'h55); debug_addr = 5'd6;
        expect_v(T1, BYP ? 32'h0 : 32'h2A); expect_v(D1, BYP ? 32'h55 : 32'h0);
        expect_v(D0, 0); expect_v(T0, 0); expect_v(PC, 1); expect_v(DBG, 0);
        tk();
        idle();
        expect_v(D1, 32'h55); expect_v(T1, 0); expect_v(PC, 0); expect_v(DBG, 32'h55);
        tk();

        // no-ops: issue to r0, CDB tag 0, issue with tag 0
        setrd(0, 5); issue(0, 8'h50); cdb(8'h00, 32'hBAD);
        tk();
        idle();
        expect_v(T0, 0); expect_v(D0, 0); expect_v(D1, 32'hDEADBEEF); expect_v(T1, 0); expect_v(PC, 0);
        issue(5, 8'h00);
        tk();
        idle();
        expect_v(T1, 0); expect_v(PC, 0);
        tk();

        // reset dominates issue and broadcast
        issue(12, 8'h60);
        tk();
        issue(13, 8'h61); cdb(8'h60, 32'h77); rst = 1'b1;
        tk();
        idle(); rst = 1'b0; setrd(12, 5); debug_addr = 5'd9;
        expect_v(D0, 0); expect_v(T0, 0); expect_v(D1, 0); expect_v(PC, 0); expect_v(DBG, 0);
        tk();
        setrd(13, 6);
        expect_v(T0, 0); expect_v(D1, 0); expect_v(T1, 0);
        tk();

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rat_regfile.md
# rat_regfile

Parametrised register file with an integrated register alias table (RAT) for the Tomasulo issue/writeback path. It generalises the core register file:
- N read ports, each returning operand data plus the producing reservation-station tag.
- A CDB broadcast retires every matching alias in one cycle.
- A flush clears all aliases after a mispredict.
- An optional same-cycle CDB bypass is available (see Configuration).

It sits between the IS stage (operand fetch/rename) and the CDB arbiter, and it keeps the debug read port used by the board display.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural registers (power of two); r0 hardwired zero
- TAG_W, 8, tag width; tag 0 = "value ready, no producer"; bits [TAG_W-1:5] FU type, [4:0] RS index
- NRD, 2, read ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW], AW=$clog2(NREGS)
- rd_data  out  NRD*XLEN  register value per port
- rd_tag  out  NRD*TAG_W  alias tag per port (0 = rd_data valid)
- iss_en  in  1  issue writes rename
- iss_rd  in  AW  destination register of issued instruction
- iss_tag  in  TAG_W  tag of RS allocated to it
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting RS tag
- cdb_data  in  XLEN  broadcast result
- flush  in  1  clear all aliases
- pend_cnt  out  AW+1  number of registers with nonzero alias (registered)
- debug_addr  in  AW  debug read address
- debug_data  out  XLEN  register value, combinational, 0 for r0

## Operation
- State:
  - reg[1..NREGS-1] of XLEN.
  - rat[0..NREGS-1] of TAG_W; rat[0] is held at 0 permanently.
- Reads are combinational:
  - rd_data = (addr==0) ? 0 : reg[addr]
  - rd_tag = rat[addr]
- Per-cycle update, evaluated against current-cycle state:
  - CDB write: if cdb_valid && cdb_tag!=0, then every r≥1 with rat[r]==cdb_tag takes reg[r]<=cdb_data and rat[r]<=0. Multiple matches are all updated.
  - Issue: if iss_en && iss_rd!=0 && iss_tag!=0 && !flush, then rat[iss_rd]<=iss_tag.
    - An issue to r0 or with iss_tag==0 is a no-op.
  - Flush: rat[all]<=0 and reg contents are kept.
- Priority on the same register in the same cycle:
  - flush > issue > CDB tag clear.
  - The CDB data write still occurs when issue or flush wins. With issue+CDB on the same reg, reg takes cdb_data and rat takes iss_tag.
- cdb_valid with cdb_tag==0 is ignored.
- pend_cnt <= popcount of the next-state rat; it therefore always equals the popcount of the current rat.
- rst: reg[*]<=0, rat[*]<=0, pend_cnt<=0. Reset dominates all other inputs, including mid-flush or mid-broadcast.

## Timing
- Read-after-issue: an alias written at edge n is visible on rd_tag from cycle n+1.
- CDB writeback:
  - data and tag clear become visible the cycle after the broadcast, without bypass;
  - they are visible the same cycle, with bypass.
- Flush takes effect on the next edge; in cycle n+1 all rd_tag=0 and pend_cnt=0.
- No handshake: inputs are sampled every edge, and there is no backpressure.
- Outputs after reset: rd_data=0, rd_tag=0, debug_data=0, pend_cnt=0.

## Configuration
- RAT_CDB_BYPASS_EN defined:
  - for each read port, if cdb_valid && cdb_tag!=0 && rat[addr]==cdb_tag && addr!=0, then rd_tag=0 and rd_data=cdb_data combinationally in the broadcast cycle;
  - debug_data is not bypassed.
- Undefined: reads reflect registered state only, and the IS stage must capture the CDB itself.

## Test plan
- Reset, then read all regs on both ports -> rd_data=0, rd_tag=0, pend_cnt=0.
- Issue r5 tag 0x23, then CDB tag 0x23 data 0xDEADBEEF -> port reads r5: tag 0x23 until the broadcast, then data 0xDEADBEEF tag 0, pend_cnt 1->0.
- Issue r3 and r7 both tag 0x41 on separate cycles, then one CDB 0x41 data 0x12 -> both regs read 0x12 tag 0, pend_cnt 2->0.
- Same cycle: issue r4 tag 0x45 and CDB of r4's old tag 0x22 data 7 -> next cycle r4 data 7, tag 0x45.
- Aliases on r1,r2,r9, then flush with a concurrent issue r10 tag 0x30 -> all tags 0, r10 not renamed, pend_cnt=0, register values unchanged.
- RAT_CDB_BYPASS_EN defined: r6 aliased 0x2A, CDB 0x2A data 0x55 -> same cycle rd_tag=0, rd_data=0x55. Undefined: same cycle tag 0x2A, next cycle 0x55.
